uart: RTL and testbench

- Full-duplex 8N1 UART for the Basys3 fabric, built for Xilinx 7-series.
- RX path: deserialises `uart_rxd` into a receive FIFO, drained through a valid/ready read port.
- TX path: accepts bytes on a valid/ready write port into a transmit FIFO and serialises them on `uart_txd`.
- Sits between the board USB-UART pins and on-chip byte-stream consumers and producers.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART.
// Holds the frame geometry (data width, data bit count, stop bit count), the RX/TX
// state encodings and the start-up delay that covers 7-series FIFO reset recovery.
package uart_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned READY_DLY  = 16;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxBreak
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push       write push_data when not full (dropped when full)
//   pop        retire the head entry when not empty
//   pop_data   head entry, valid whenever empty is low
//   full/empty occupancy flags
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART with an RX and a TX FIFO.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   uart_ready                            out of reset, FIFOs usable
//   uart_rd_data/valid/ready              FWFT read port of the RX FIFO
//   uart_wr_data/valid/ready              write port of the TX FIFO
//   uart_rxd, uart_txd                    serial pins, idle high
// UART_MODE "LOOPBACK" routes the serialiser into the deserialiser and parks uart_txd at 1.
module uart
    import uart_pkg::*;
#(
    parameter string       DEVICE     = "7SERIES",
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter string       UART_MODE  = "NORMAL",
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  uart_ready,
    output logic [DATA_WIDTH-1:0] uart_rd_data,
    output logic                  uart_rd_valid,
    input  logic                  uart_rd_ready,
    input  logic [DATA_WIDTH-1:0] uart_wr_data,
    input  logic                  uart_wr_valid,
    output logic                  uart_wr_ready,
    input  logic                  uart_rxd,
    output logic                  uart_txd
);

    localparam int unsigned BIT_CNT   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned HALF_CNT  = BIT_CNT / 2;
    localparam int unsigned CNT_W     = $clog2(BIT_CNT + 1);
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);
    localparam int unsigned RDY_W     = $clog2(READY_DLY + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [RDY_W-1:0] RDY_DONE  = RDY_W'(READY_DLY);
    localparam logic [RDY_W-1:0] RDY_ONE   = RDY_W'(1);
    localparam bit               LOOPBACK  = (UART_MODE == "LOOPBACK");

    if (DEVICE != "7SERIES") begin : gen_bad_device
        $error("uart: unsupported DEVICE %s", DEVICE);
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("uart: FIFO_DEPTH must be a power of 2 and at least 4");
    end

    // Start-up hold-off: FIFOs are not trusted until the counter saturates.
    logic [RDY_W-1:0] rdy_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_cnt_q <= '0;
        end else if (rdy_cnt_q != RDY_DONE) begin
            rdy_cnt_q <= rdy_cnt_q + RDY_ONE;
        end
    end

    assign uart_ready = (rdy_cnt_q == RDY_DONE);

    // RX synchroniser plus one extra stage for falling-edge detection.
    logic txd_q, txd_d;
    logic rx_line;
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    assign rx_line = LOOPBACK ? txd_q : uart_rxd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rx_line;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // FIFOs
    logic                  rx_push, rx_full, rx_empty;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;

    assign uart_rd_valid = uart_ready && !rx_empty;
    assign uart_wr_ready = uart_ready && !tx_full;
    assign tx_push       = uart_wr_valid && uart_wr_ready;

    uart_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push && !rx_full),
        .push_data (rx_shift_q),
        .pop       (uart_rd_valid && uart_rd_ready),
        .pop_data  (uart_rd_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    uart_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (uart_wr_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // RX FSM
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0] rx_bit_q, rx_bit_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_ONE;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (uart_ready && rxd_prev_q && !rxd_sync_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // Still high at mid start bit: treat as a glitch.
                    rx_state_d = rxd_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    rx_bit_d   = rx_bit_q + IDX_ONE;
                    if (rx_bit_q == IDX_LAST) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_push    = rxd_sync_q;
                    rx_state_d = rxd_sync_q ? RxIdle : RxBreak;
                end
            end
            RxBreak: begin
                rx_cnt_d = '0;
                if (rxd_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // TX FSM; txd is driven from the current state so the line is purely registered.
    tx_state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_ONE;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = tx_shift_q[0];
            default: txd_d = 1'b1;
        endcase
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + IDX_ONE;
                    if (tx_bit_q == IDX_LAST) tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q != STOP_LAST) begin
                        tx_bit_d = tx_bit_q + IDX_ONE;
                    end else if (!tx_empty) begin
                        // Chain straight into the next start bit.
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign uart_txd = LOOPBACK ? 1'b1 : txd_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: a default-rate instance for exact 115200 bit timing, and two
// fast instances (10 clk per bit) so stream/overrun/loopback runs stay short.
module tb_uart;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    logic       ready_d, rd_valid_d, rd_ready_d = 1'b0, wr_valid_d = 1'b0, wr_ready_d;
    logic [7:0] rd_data_d, wr_data_d = 8'h00;
    logic       rxd_d = 1'b1, txd_d;
    logic       ready_f, rd_valid_f, rd_ready_f = 1'b0, wr_valid_f = 1'b0, wr_ready_f;
    logic [7:0] rd_data_f, wr_data_f = 8'h00;
    logic       rxd_f = 1'b1, txd_f;
    logic       ready_l, rd_valid_l, rd_ready_l = 1'b0, wr_valid_l = 1'b0, wr_ready_l;
    logic [7:0] rd_data_l, wr_data_l = 8'h00;
    logic       rxd_l = 1'b1, txd_l;

    always #5 clk = ~clk;

    uart u_dut (
        .clk (clk), .rst (rst), .uart_ready (ready_d),
        .uart_rd_data (rd_data_d), .uart_rd_valid (rd_valid_d), .uart_rd_ready (rd_ready_d),
        .uart_wr_data (wr_data_d), .uart_wr_valid (wr_valid_d), .uart_wr_ready (wr_ready_d),
        .uart_rxd (rxd_d), .uart_txd (txd_d)
    );

    uart #(.BAUD_RATE(10000000)) u_fast (
        .clk (clk), .rst (rst), .uart_ready (ready_f),
        .uart_rd_data (rd_data_f), .uart_rd_valid (rd_valid_f), .uart_rd_ready (rd_ready_f),
        .uart_wr_data (wr_data_f), .uart_wr_valid (wr_valid_f), .uart_wr_ready (wr_ready_f),
        .uart_rxd (rxd_f), .uart_txd (txd_f)
    );

    uart #(.BAUD_RATE(10000000), .UART_MODE("LOOPBACK")) u_loop (
        .clk (clk), .rst (rst), .uart_ready (ready_l),
        .uart_rd_data (rd_data_l), .uart_rd_valid (rd_valid_l), .uart_rd_ready (rd_ready_l),
        .uart_wr_data (wr_data_l), .uart_wr_valid (wr_valid_l), .uart_wr_ready (wr_ready_l),
        .uart_rxd (rxd_l), .uart_txd (txd_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rv(input int sel);
        if (sel == 0) return rd_valid_d;
        if (sel == 1) return rd_valid_f;
        return rd_valid_l;
    endfunction

    function automatic logic [7:0] rdat(input int sel);
        if (sel == 0) return rd_data_d;
        if (sel == 1) return rd_data_f;
        return rd_data_l;
    endfunction

    task automatic set_rdy(input int sel, input logic v);
        if (sel == 0) rd_ready_d = v;
        else if (sel == 1) rd_ready_f = v;
        else rd_ready_l = v;
    endtask

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) rxd_d = v;
        else rxd_f = v;
    endtask

    // Drives one 8N1 frame; stop cell lasts stop_len cycles, line left high afterwards.
    task automatic rx_send(input int sel, input logic [7:0] b, input logic stop, input int bc,
                           input int stop_len);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            set_rxd(sel, f[k]);
            repeat ((k == 9) ? stop_len : bc) @(negedge clk);
        end
        set_rxd(sel, 1'b1);
    endtask

    // Waits (bounded) for a byte, compares it with the scoreboard head, then accepts it.
    task automatic take_one(input int sel, input string tag);
        int         n;
        logic [7:0] exp_b;
        n = 0;
        while (!rv(sel) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rv(sel)), 32'd1);
        if (!rv(sel)) return;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check(tag, 32'(rdat(sel)), 32'(exp_b));
        set_rdy(sel, 1'b1);
        @(negedge clk);
        set_rdy(sel, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] frame;
        logic       found;
        logic [7:0] b;

        // Reset and start-up hold-off.
        repeat (16) @(negedge clk);
        check("rst_ready", 32'(ready_d), 32'd0);
        check("rst_rd_valid", 32'(rd_valid_d), 32'd0);
        check("rst_wr_ready", 32'(wr_ready_d), 32'd0);
        check("rst_txd", 32'(txd_d), 32'd1);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ready_clk%0d", i), 32'(ready_d), 32'(i == 16));
            check($sformatf("wr_ready_clk%0d", i), 32'(wr_ready_d), 32'(i == 16));
            check($sformatf("txd_clk%0d", i), 32'(txd_d), 32'd1);
        end
        check("loop_txd_idle", 32'(txd_l), 32'd1);

        // TX bit cells at 115200: start at E2, 868 clk per cell, LSB first, stop high.
        @(negedge clk);
        check("tx_wr_ready", 32'(wr_ready_d), 32'd1);
        wr_data_d  = 8'h4B;
        wr_valid_d = 1'b1;
        @(posedge clk);
        #1;
        wr_valid_d = 1'b0;
        @(posedge clk);
        #1;
        check("tx_lat_e1", 32'(txd_d), 32'd1);
        @(posedge clk);
        #1;
        frame = {1'b1, 8'h4B, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 868; c++) begin
                if (k != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (c == 0 || c == 867)
                    check($sformatf("tx_cell%0d_c%0d", k, c), 32'(txd_d), 32'(frame[k]));
            end
        end
        @(posedge clk);
        #1;
        check("tx_idle_after", 32'(txd_d), 32'd1);

        // Single RX byte at 115200; valid within one bit after stop centre, held until ready.
        @(negedge clk);
        exp_q.push_back(8'hA5);
        rx_send(0, 8'hA5, 1'b1, 868, 434);
        found = 1'b0;
        for (int i = 0; i < 868 && !found; i++) begin
            if (rd_valid_d) found = 1'b1;
            else @(negedge clk);
        end
        check("rx_single_latency", 32'(found), 32'd1);
        repeat (100) @(negedge clk);
        check("rx_single_hold_valid", 32'(rd_valid_d), 32'd1);
        check("rx_single_hold_data", 32'(rd_data_d), 32'hA5);
        take_one(0, "rx_single");
        check("rx_single_drained", 32'(rd_valid_d), 32'd0);

        // 128-byte stream on the fast instance with a slow, pulsed consumer.
        fork
            begin
                for (int i = 0; i < 128; i++) begin
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    rx_send(1, b, 1'b1, 10, 10);
                end
            end
            begin
                for (int i = 0; i < 128; i++) begin
                    take_one(1, $sformatf("stream%0d", i));
                    repeat (60) @(negedge clk);
                end
            end
        join
        check("stream_all_seen", 32'(exp_q.size()), 32'd0);

        // Line errors: short low pulse (below half a bit), then a framing error.
        rxd_f = 1'b0;
        repeat (2) @(negedge clk);
        rxd_f = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_byte", 32'(rd_valid_f), 32'd0);
        rx_send(1, 8'h3C, 1'b0, 10, 10);
        repeat (50) @(negedge clk);
        check("framing_no_byte", 32'(rd_valid_f), 32'd0);
        exp_q.push_back(8'h81);
        rx_send(1, 8'h81, 1'b1, 10, 10);
        take_one(1, "after_errors");

        // Overrun: 20 bytes with no consumer; only the first 16 survive.
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            rx_send(1, 8'(i), 1'b1, 10, 10);
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 16; i++) take_one(1, $sformatf("overrun%0d", i));
        repeat (30) @(negedge clk);
        check("overrun_dropped", 32'(rd_valid_f), 32'd0);

        // Loopback: three back-to-back writes come back in order.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h55 : (i == 1) ? 8'hFF : 8'h00;
            exp_q.push_back(b);
            wr_data_l  = b;
            wr_valid_l = 1'b1;
            @(negedge clk);
        end
        wr_valid_l = 1'b0;
        for (int i = 0; i < 3; i++) take_one(2, $sformatf("loop%0d", i));
        check("loop_txd_held", 32'(txd_l), 32'd1);
        check("loop_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
